// File: rtl/sim_pkg.sv
// Shared types and defaults for the simulation watchdog.
package sim_pkg;

  typedef enum logic [2:0] {
    END_NONE       = 3'd0,
    END_PASS       = 3'd1,
    END_FAIL       = 3'd2,
    END_TMO_GLOBAL = 3'd3,
    END_TMO_HB     = 3'd4
  } end_code_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_REPORT = 2'd1,
    ST_HALT   = 2'd2
  } wd_state_t;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;
  localparam int unsigned DEF_HB_TIMEOUT     = 1000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
  parameter int unsigned          WIDTH = 8,
  parameter logic [WIDTH-1:0]     MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sim_watchdog.sv
// Simulation watchdog: ends a test on DUT completion, global timeout or heartbeat loss.
// Heartbeat supervision is compiled in only when SIM_WATCHDOG_HB_EN is defined.
module sim_watchdog
  import sim_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned HB_TIMEOUT     = DEF_HB_TIMEOUT,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hb,
  input  logic             done_vld,
  input  logic             done_pass,
  output logic             end_vld,
  input  logic             end_ack,
  output logic [2:0]       end_code,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [CNT_W-1:0] GLOBAL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  wd_state_t        state_q, state_d;
  end_code_t        end_code_q, end_code_d;
  logic [CNT_W-1:0] cyc;
  logic             in_run;
  logic             run_adv;
  logic             hb_tmo;

  assign in_run = (state_q == ST_RUN);

  // Counters only advance in RUN cycles that do not end the run, so the
  // reported count is the value seen in the decisive cycle.
  assign run_adv = in_run && (state_d == ST_RUN);

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (run_adv),
    .cnt (cyc)
  );

`ifdef SIM_WATCHDOG_HB_EN
  localparam int unsigned     HB_W    = $clog2(HB_TIMEOUT);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_TIMEOUT - 1);

  logic [HB_W-1:0] hb_cnt;

  sat_counter #(
    .WIDTH (HB_W),
    .MAX   (HB_LAST)
  ) u_hb_cnt (
    .clk (clk),
    .rst (rst),
    .clr (in_run && hb),
    .en  (run_adv),
    .cnt (hb_cnt)
  );

  assign hb_tmo = (hb_cnt == HB_LAST) && !hb;
`else
  logic hb_unused;

  assign hb_unused = hb;
  assign hb_tmo    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    end_code_d = end_code_q;
    case (state_q)
      ST_RUN: begin
        if (done_vld) begin
          end_code_d = done_pass ? END_PASS : END_FAIL;
          state_d    = ST_REPORT;
        end else if (cyc == GLOBAL_LAST) begin
          end_code_d = END_TMO_GLOBAL;
          state_d    = ST_REPORT;
        end else if (hb_tmo) begin
          end_code_d = END_TMO_HB;
          state_d    = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (end_ack) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      end_code_q <= END_NONE;
    end else begin
      state_q    <= state_d;
      end_code_q <= end_code_d;
    end
  end

  assign end_vld   = (state_q == ST_REPORT);
  assign end_code  = end_code_q;
  assign cycle_cnt = cyc;

endmodule
